// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants and types for the shift-register command sequencer.
package shift_seq_ctrl_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SH_DN = 2'b01;
  localparam logic [1:0] MODE_SH_UP = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [1:0] FILL_ZERO  = 2'b00;
  localparam logic [1:0] FILL_ONES  = 2'b01;
  localparam logic [1:0] FILL_ROT   = 2'b10;
  localparam logic [1:0] FILL_ARITH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_cnt.sv
// Loadable down-counter for shift steps; last_o marks the final step.
module shift_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences load/shift commands onto an external 8-bit universal
// shift register, using its Q bus for rotate and sign fill.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  input  logic [1:0]       fill,
  input  logic             load_en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] q_in,
  output logic             a0,
  output logic             a1,
  output logic [WIDTH-1:0] d_out,
  output logic             dl,
  output logic             dr,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             dir_q;
  logic [CNT_W-1:0] amt_q;
  logic [1:0]       fill_q;
  logic [WIDTH-1:0] din_q;
  logic             take;
  logic             cnt_ld;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_last;
  logic [1:0]       mode;

  assign take = (state_q == S_IDLE) && start;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      amt_q   <= '0;
      fill_q  <= FILL_ZERO;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        dir_q  <= dir;
        amt_q  <= amount;
        fill_q <= fill;
        din_q  <= din;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (load_en)
            state_d = S_LOAD;
          else if (amount != '0)
            state_d = S_SHIFT;
          else
            state_d = S_DONE;
        end
      end
      S_LOAD:
        state_d = (amt_q != '0) ? S_SHIFT : S_DONE;
      S_SHIFT:
        if (cnt_last) state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Entry into SHIFT comes straight from IDLE (live amount) or via LOAD.
  assign cnt_ld  = (state_d == S_SHIFT) && (state_q != S_SHIFT);
  assign cnt_val = (state_q == S_IDLE) ? amount : amt_q;

  shift_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .load_i (cnt_ld),
    .val_i  (cnt_val),
    .dec_i  (state_q == S_SHIFT),
    .last_o (cnt_last)
  );

  always_comb begin
    mode  = MODE_HOLD;
    d_out = '0;
    dl    = 1'b0;
    dr    = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE):
        busy = 1'b0;
      (state_q == S_LOAD): begin
        mode  = MODE_LOAD;
        d_out = din_q;
      end
      (state_q == S_SHIFT): begin
        mode = dir_q ? MODE_SH_UP : MODE_SH_DN;
        unique case (fill_q)
          FILL_ONES: begin
            dl = 1'b1;
            dr = 1'b1;
          end
          FILL_ROT: begin
            dl = dir_q & q_in[WIDTH-1];
            dr = ~dir_q & q_in[0];
          end
          FILL_ARITH:
            dr = ~dir_q & q_in[WIDTH-1];
          default: ;
        endcase
      end
      (state_q == S_DONE):
        done = 1'b1;
      default: ;
    endcase
  end

  assign a1 = mode[1];
  assign a0 = mode[0];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench: sequencer driving a behavioural universal shift register.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] amount = '0;
  logic [1:0] fill = '0;
  logic       load_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] q = 8'h00;
  logic       a0, a1, dl, dr, busy, done;
  logic [7:0] d_out;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       dir;
    logic [2:0] amt;
    logic [1:0] fill;
    logic [7:0] exp_q;
    int         exp_busy;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  shift_seq_ctrl dut (
    .clock   (clk),
    .reset   (rst_n),
    .start   (start),
    .dir     (dir),
    .amount  (amount),
    .fill    (fill),
    .load_en (load_en),
    .din     (din),
    .q_in    (q),
    .a0      (a0),
    .a1      (a1),
    .d_out   (d_out),
    .dl      (dl),
    .dr      (dr),
    .busy    (busy),
    .done    (done)
  );

  // Behavioural model of the external universal shift register
  always @(posedge clk) begin
    case ({a1, a0})
      2'b01:   q <= {dr, q[7:1]};
      2'b10:   q <= {q[6:0], dl};
      2'b11:   q <= d_out;
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    load_en = v.ld;
    din     = v.din;
    dir     = v.dir;
    amount  = v.amt;
    fill    = v.fill;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    load_en = ~v.ld;
    din     = ~v.din;
    dir     = ~v.dir;
    amount  = ~v.amt;
    fill    = ~v.fill;
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int bc, dc;
    bc = 0;
    dc = 0;
    issue(v);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (done) dc++;
    end
    chk({nm, " busy_cycles"}, bc, v.exp_busy);
    chk({nm, " done_pulses"}, dc, 1);
    chk({nm, " q"}, q, v.exp_q);
    chk({nm, " idle_mode"}, {a1, a0}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] m_exp[6];
    logic       d_exp[6];
    vec_t       v;
    int         bc, dc;

    vecs[0]  = '{1'b1, 8'hB4, 1'b0, 3'd3, 2'b00, 8'h16, 5};
    vecs[1]  = '{1'b1, 8'h81, 1'b1, 3'd1, 2'b10, 8'h03, 3};
    vecs[2]  = '{1'b1, 8'h90, 1'b0, 3'd2, 2'b11, 8'hE4, 4};
    vecs[3]  = '{1'b1, 8'h5A, 1'b0, 3'd0, 2'b00, 8'h5A, 2};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 3'd0, 2'b00, 8'h5A, 1};
    vecs[5]  = '{1'b1, 8'h0F, 1'b1, 3'd4, 2'b01, 8'hFF, 6};
    vecs[6]  = '{1'b1, 8'h96, 1'b0, 3'd7, 2'b10, 8'h2D, 9};
    vecs[7]  = '{1'b1, 8'h81, 1'b1, 3'd3, 2'b11, 8'h08, 5};
    vecs[8]  = '{1'b0, 8'hFF, 1'b0, 3'd2, 2'b01, 8'hC2, 3};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 3'd1, 2'b10, 8'h85, 2};
    vecs[10] = '{1'b1, 8'hA5, 1'b0, 3'd1, 2'b11, 8'hD2, 3};

    // Reset state, with q and command inputs non-zero
    load_en = 1'b1;
    din     = 8'hFF;
    amount  = 3'd5;
    fill    = 2'b01;
    #12;
    chk("rst mode", {a1, a0}, 2'b00);
    chk("rst d_out", d_out, 8'h00);
    chk("rst serial", {dl, dr}, 2'b00);
    chk("rst busy_done", {busy, done}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Mode sequence for load B4, dir 0, 3 steps
    m_exp = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    d_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    issue(vecs[0]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("seq mode%0d", i), {a1, a0}, m_exp[i]);
      chk($sformatf("seq done%0d", i), done, d_exp[i]);
    end
    chk("seq q", q, 8'h16);

    // Start during SHIFT and DONE is ignored
    v = '{1'b1, 8'h3C, 1'b0, 3'd4, 2'b00, 8'h03, 6};
    issue(v);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start   = 1'b1;
    amount  = 3'd1;
    din     = 8'hFF;
    load_en = 1'b1;
    dir     = 1'b1;
    bc = 3;
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (done) dc++;
    end
    start = 1'b0;
    chk("ign busy_cycles", bc, 6);
    chk("ign done_pulses", dc, 1);
    @(negedge clk);
    chk("ign stays_idle", busy, 1'b0);
    chk("ign q", q, 8'h03);

    // Asynchronous reset in the middle of SHIFT
    v = '{1'b1, 8'hF0, 1'b0, 3'd5, 2'b01, 8'h00, 0};
    issue(v);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ar dr_before", dr, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar mode", {a1, a0}, 2'b00);
    chk("ar busy_done", {busy, done}, 2'b00);
    chk("ar serial", {dl, dr}, 2'b00);
    chk("ar d_out", d_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("ar q_held", q, 8'hF8);
    rst_n = 1'b1;
    run_cmd(vecs[1], "ar_fresh");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the 8-bit universal shift register (mode pair A1:A0 — 00 hold, 01 shift toward Q0 with DR into Q7, 10 shift toward Q7 with DL into Q0, 11 parallel load).
- Accepts one command per handshake: optional parallel load, then N shift steps in one direction with a selectable fill policy.
- Drives the register's mode, data and serial inputs cycle by cycle; reads its Q bus back for rotate and sign fill.
- Signals completion with a one-cycle done pulse.

Parameters:
WIDTH, 8, register width (fixed at 8 for the existing register).
CNT_W, 3, shift-count width; equals clog2(WIDTH).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  command strobe; sampled only in IDLE.
dir  in  1  0 = shift toward Q0 (mode 01), 1 = shift toward Q7 (mode 10).
amount  in  CNT_W  number of shift steps, 0..7.
fill  in  2  00 zero, 01 ones, 10 rotate, 11 arithmetic.
load_en  in  1  1 = parallel-load din before shifting.
din  in  WIDTH  parallel load data.
q_in  in  WIDTH  register Q7..Q0 feedback.
a0  out  1  register mode select LSB.
a1  out  1  register mode select MSB.
d_out  out  WIDTH  to register D7..D0.
dl  out  1  serial input into Q0 (mode 10).
dr  out  1  serial input into Q7 (mode 01).
busy  out  1  high while a command is in progress.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; latched command registers and counter cleared.
  - Outputs: a1:a0=00, d_out=0x00, dl=0, dr=0, busy=0, done=0.
  - Reset mid-command abandons the command; the register holds whatever it last clocked.
- FSM states: IDLE, LOAD, SHIFT, DONE. Outputs are Moore, decoded from state and latched command; dl/dr are also combinational from q_in.
- IDLE: a1:a0=00. When start=1 at a clock edge, latch dir, amount, fill, load_en and din. Next state:
  - LOAD if load_en=1;
  - else SHIFT if amount≠0;
  - else DONE.
- LOAD (1 cycle): a1:a0=11, d_out=latched din. Next state is SHIFT if amount≠0, else DONE.
- SHIFT (exactly `amount` cycles):
  - a1:a0=01 when dir=0, 10 when dir=1.
  - Counter loads `amount` at entry and decrements each SHIFT edge; exit to DONE on the edge where counter=1.
- DONE (1 cycle): a1:a0=00, done=1. Next state IDLE.
- busy=1 in LOAD, SHIFT and DONE; 0 in IDLE.
- start is ignored whenever state≠IDLE; no queuing. A start arriving in DONE is lost.
- Latency, from the start edge to the done edge: (load_en ? 1 : 0) + amount + 1 cycles. Minimum 1 cycle: amount=0, load_en=0 goes IDLE→DONE.
- Serial fill, valid only in SHIFT; dl=dr=0 in all other states:
  - zero: dl=0, dr=0.
  - ones: dl=1, dr=1.
  - rotate: dr=q_in[0] when dir=0, dl=q_in[7] when dir=1.
  - arithmetic: dr=q_in[7] when dir=0 (sign preserved); dl=0 when dir=1 (logical left).
- Only the serial input matching the active direction matters; the other is driven 0.
- d_out=0x00 outside LOAD.
- Command inputs may change freely after the start edge; only latched copies are used.

Decomposition:
- Shared package holds:
  - mode constants MODE_HOLD=2'b00, MODE_SH_DN=2'b01, MODE_SH_UP=2'b10, MODE_LOAD=2'b11;
  - fill encodings FILL_ZERO, FILL_ONES, FILL_ROT, FILL_ARITH;
  - state enum type.
- One natural sub-module: shift_cnt, a loadable CNT_W-bit down-counter with a last-step flag, reset asynchronously to 0.
- For verification, instance the controller above the existing register in a test wrapper; the controller contains no register storage of its own.

Test Plan:
1. Load 0xB4, dir=0, amount=3, fill=zero -> a1:a0 sequence 11,01,01,01,00; done at cycle 5 after start; Q=0x16.
2. Load 0x81, dir=1, amount=1, fill=rotate -> dl=1 during the SHIFT cycle; final Q=0x03; busy high for 3 cycles.
3. Load 0x90, dir=0, amount=2, fill=arithmetic -> dr=1 on both shift cycles; Q=0xE4.
4. Register pre-set to 0x5A; start with load_en=0, amount=0 -> next cycle DONE with done=1, a1:a0 stays 00, Q remains 0x5A.
5. Start during SHIFT with different amount/din -> ignored; original command completes unchanged; exactly one done pulse.
6. Assert reset=0 mid-SHIFT, asynchronously between edges -> outputs immediately a1:a0=00, busy=0, done=0, dl=dr=0; after release, a fresh start executes normally.
